// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and parameter limits for the pipeline hazard controller.
// Also provides a clamp helper so out-of-range parameters degrade to the nearest legal value.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int BUBBLES_MIN = 1;
  localparam int BUBBLES_MAX = 3;
  localparam int FLUSH_MIN   = 1;
  localparam int FLUSH_MAX   = 3;

  function automatic int clamp_range(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Decode/execute hazard information in, pipeline stall/flush controls and perf counters out.
// The slave side is the hazard controller; the master side is the datapath.
interface hazard_ctrl_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             ctr_clear;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_rd_addr, ex_mem_read, ex_redirect, ctr_clear,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           busy, stall_cycles, redirect_count
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_rd_addr, ex_mem_read, ex_redirect, ctr_clear,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           busy, stall_cycles, redirect_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear wins over increment.
// Single-cycle update, no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall and redirect flush controller for the 5-stage core; controls are Mealy (same cycle).
// Counts stall cycles and accepted redirects with saturating counters.
module hazard_ctrl_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES      = 1,
  parameter int REDIRECT_FLUSH_CYCLES = 1,
  parameter int CNT_W                 = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_ctrl_unit_if.slave  bus
);

  localparam int LU_B = clamp_range(LOAD_USE_BUBBLES, BUBBLES_MIN, BUBBLES_MAX);
  localparam int RF_B = clamp_range(REDIRECT_FLUSH_CYCLES, FLUSH_MIN, FLUSH_MAX);

  // A single bubble or flush cycle is fully handled in RUN; no extra state needed.
  localparam state_e     LU_NEXT    = (LU_B > 1) ? LU_STALL : RUN;
  localparam state_e     RF_NEXT    = (RF_B > 1) ? REDIRECT : RUN;
  localparam logic [1:0] LU_CNT_INI = 2'(LU_B - 1);
  localparam logic [1:0] RF_CNT_INI = 2'(RF_B - 1);

  state_e     r_state;
  logic [1:0] r_cnt;

  logic w_load_use;
  logic w_stall;
  logic w_flush;
  logic w_redirect_acc;

  always_comb begin
    w_load_use = bus.ex_mem_read && (bus.ex_rd_addr != REG_ZERO) &&
                 ((bus.id_uses_rs1 && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
                  (bus.id_uses_rs2 && (bus.id_rs2_addr == bus.ex_rd_addr)));
  end

  always_comb begin
    w_stall        = 1'b0;
    w_flush        = 1'b0;
    w_redirect_acc = 1'b0;
    if (rst_n) begin
      case (r_state)
        RUN: begin
          if (bus.ex_redirect) begin
            w_flush        = 1'b1;
            w_redirect_acc = 1'b1;
          end else if (w_load_use) begin
            w_stall = 1'b1;
          end
        end
        LU_STALL: begin
          if (bus.ex_redirect) begin
            w_flush        = 1'b1;
            w_redirect_acc = 1'b1;
          end else begin
            w_stall = 1'b1;
          end
        end
        REDIRECT: w_flush = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.ex_redirect) begin
            r_state <= RF_NEXT;
            r_cnt   <= RF_CNT_INI;
          end else if (w_load_use) begin
            r_state <= LU_NEXT;
            r_cnt   <= LU_CNT_INI;
          end
        end
        LU_STALL: begin
          if (bus.ex_redirect) begin
            r_state <= RF_NEXT;
            r_cnt   <= RF_CNT_INI;
          end else if (r_cnt <= 2'd1) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        REDIRECT: begin
          if (r_cnt <= 2'd1) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  assign bus.pc_stall    = w_stall;
  assign bus.if_id_stall = w_stall;
  assign bus.id_ex_stall = w_stall;
  assign bus.if_id_flush = w_flush;
  assign bus.id_ex_flush = w_flush;
  assign bus.busy        = rst_n && ((r_state == LU_STALL) || (r_state == REDIRECT));

  sat_counter #(.W(CNT_W)) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.ctr_clear),
    .inc   (w_stall),
    .count (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redirect_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.ctr_clear),
    .inc   (w_redirect_acc),
    .count (bus.redirect_count)
  );

endmodule
